// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module  : mux_scan_pkg
// Purpose : Shared widths and state encoding for the mux scan controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

    localparam int SEL_W  = 2;
    localparam int NCH    = 4;
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// Module  : settle_timer
// Purpose : Loadable down-counter that flags zero; it stops at zero.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module settle_timer
    import mux_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WCNT_W-1:0] load_val_i,
    output logic              zero_o
);

    logic [WCNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module  : mux_scan_ctrl
// Purpose : Walks a 4:1 mux select, samples f_in per channel, reports a word.
//           MUX_SCAN_CONT_EN: start held on the last sample chains scans.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             f_in,
    output logic [SEL_W-1:0] sel,
    output logic [NCH-1:0]   data,
    output logic             busy,
    output logic             done
);

    localparam logic [WCNT_W-1:0] C_RELOAD = WCNT_W'(SETTLE - 1);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_settle_chk
            $error("mux_scan_ctrl: SETTLE must be in 1..15");
        end
    endgenerate

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [2:0]       shadow_q;
    logic [NCH-1:0]   data_q;
    logic             done_q;

    logic w_last;
    logic w_cont;
    logic w_load;
    logic w_zero;

    assign w_last = (sel_q == SEL_W'(NCH - 1));

`ifdef MUX_SCAN_CONT_EN
    assign w_cont = start;
`else
    assign w_cont = 1'b0;
`endif

    // Timer reloads on every entry into the settle state.
    assign w_load = ((state_q == ST_IDLE) && start) ||
                    ((state_q == ST_SAMPLE) && (!w_last || w_cont));

    settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_load),
        .load_val_i (C_RELOAD),
        .zero_o     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sel_q <= '0;
                    if (start) begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_zero) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (!w_last) begin
                        case (sel_q)
                            2'd0:    shadow_q[0] <= f_in;
                            2'd1:    shadow_q[1] <= f_in;
                            default: shadow_q[2] <= f_in;
                        endcase
                        sel_q   <= sel_q + 1'b1;
                        state_q <= ST_SETTLE;
                    end else begin
                        data_q  <= {f_in, shadow_q};
                        done_q  <= 1'b1;
                        sel_q   <= '0;
                        state_q <= w_cont ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel  = sel_q;
    assign data = data_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// Module  : tb_mux_scan_ctrl
// Purpose : Self-checking bench, two controllers (SETTLE=1, SETTLE=3) each
//           closing the loop through a behavioural 4:1 mux.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3;
    logic [3:0] w1, w3;
    logic       f1, f3;
    logic [1:0] sel1, sel3;
    logic [3:0] data1, data3;
    logic       busy1, busy3, done1, done3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // mux4to1 in the loop: f = w[S]
    assign f1 = w1[sel1];
    assign f3 = w3[sel3];

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .f_in(f1),
        .sel(sel1), .data(data1), .busy(busy1), .done(done1)
    );

    mux_scan_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .f_in(f3),
        .sel(sel3), .data(data3), .busy(busy3), .done(done3)
    );

    typedef struct {
        logic [3:0] w;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t tbl[6];
    int   sel_log[16];

`ifdef MUX_SCAN_CONT_EN
    localparam int C_PERIOD = 8;
`else
    localparam int C_PERIOD = 9;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulses start for one edge, then counts edges from acceptance to done.
    task automatic run_scan(input int which, input logic [3:0] w,
                            output int lat, output int busy_cnt);
        if (which == 1) begin w1 = w; start1 = 1'b1; end
        else begin w3 = w; start3 = 1'b1; end
        tick();
        start1 = 1'b0;
        start3 = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (((which == 1) ? done1 : done3) == 1'b0 && lat < 100) begin
            if ((which == 1) ? busy1 : busy3) busy_cnt++;
            if (lat < 16) sel_log[lat] = (which == 1) ? int'(sel1) : int'(sel3);
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, ndone, last, ok;

        tbl[0] = '{4'b1010, 4'b1010, 8};
        tbl[1] = '{4'b0001, 4'b0001, 8};
        tbl[2] = '{4'b1111, 4'b1111, 8};
        tbl[3] = '{4'b0110, 4'b0110, 8};
        tbl[4] = '{4'b0000, 4'b0000, 8};
        tbl[5] = '{4'b1000, 4'b1000, 8};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; w1 = '0; w3 = '0;
        tick(); tick();
        check("rst_sel",  32'(sel1),  0);
        check("rst_data", 32'(data1), 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_out3", {sel3, data3, busy3, done3}, 0);
        rst = 1'b0;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({sel1, data1, busy1, done1} != 8'd0) ok = 0;
        end
        check("idle_hold", ok, 1);

        // Basic scan with select trace
        run_scan(1, 4'b1010, lat, bcnt);
        check("basic_lat",  lat, 8);
        check("basic_busy", bcnt, 8);
        check("basic_data", 32'(data1), 32'b1010);
        ok = 1;
        for (int k = 0; k < 8; k++) if (sel_log[k] != k / 2) ok = 0;
        check("basic_sel_seq", ok, 1);
        tick();
        check("basic_done_width", 32'(done1), 0);

        for (int i = 0; i < 6; i++) begin
            tick();
            run_scan(1, tbl[i].w, lat, bcnt);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            check($sformatf("vec%0d_data", i), 32'(data1), 32'(tbl[i].exp_data));
            check($sformatf("vec%0d_busy", i), bcnt, tbl[i].exp_lat);
            tick();
            check($sformatf("vec%0d_done_clr", i), 32'(done1), 0);
        end

        // SETTLE=3, then data must survive input changes
        run_scan(3, 4'b0111, lat, bcnt);
        check("s3_lat",  lat, 16);
        check("s3_data", 32'(data3), 32'b0111);
        ok = 1;
        for (int k = 0; k < 16; k++) if (sel_log[k] != k / 4) ok = 0;
        check("s3_sel_seq", ok, 1);
        w3 = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        check("s3_data_hold", 32'(data3), 32'b0111);

        // Start re-pulsed mid-scan is ignored
        w1 = 4'b0001; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        ndone = 0; last = -1;
        for (int k = 0; k < 30; k++) begin
            start1 = (k == 3);
            if (done1) begin ndone++; last = k; end
            tick();
        end
        start1 = 1'b0;
        check("mid_start_ndone", ndone, 1);
        check("mid_start_lat",   last, 8);
        check("mid_start_data",  32'(data1), 32'b0001);

        // Reset in the middle of a scan
        w1 = 4'b1111; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("midrst_busy_before", 32'(busy1), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outs", {sel1, data1, busy1, done1}, 0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done1) ndone++;
            tick();
        end
        check("midrst_no_done", ndone, 0);
        run_scan(1, 4'b1111, lat, bcnt);
        check("midrst_rescan_data", 32'(data1), 32'b1111);
        check("midrst_rescan_lat",  lat, 8);

        // Start held high: back-to-back scans
        tick();
        w1 = 4'b0110; start1 = 1'b1;
        ndone = 0; last = -1; ok = 1;
        for (int t = 0; t < 45; t++) begin
            tick();
            if (done1) begin
                check($sformatf("held_data%0d", ndone), 32'(data1), 32'b0110);
                if (last >= 0)
                    check($sformatf("held_period%0d", ndone), t - last, C_PERIOD);
                last = t;
                ndone++;
            end
`ifdef MUX_SCAN_CONT_EN
            if (!busy1) ok = 0;
`endif
        end
        start1 = 1'b0;
        check("held_busy_cont", ok, 1);
        check("held_ndone_min", 32'(ndone >= 4), 1);
        for (int t = 0; t < 20; t++) tick();
        check("held_back_idle", 32'(busy1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Upstream controller for the 4-to-1 mux (mux4to1).
- Drives the mux select lines, walking through channels 0..3.
- Waits a programmable settle time on each channel, then samples the mux output `f`.
- Assembles the four samples into a 4-bit word and reports completion with a start/busy/done handshake.

Parameters:
- SETTLE, default 1: cycles the select is held before sampling. Legal range 1..15; 0 is illegal and is caught by an elaboration check.
- NCH, default 4: channel count. Fixed at 4 to match the 2-bit select.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a scan; sampled only in IDLE.
- f_in  input  1  mux output `f` fed back from mux4to1.
- sel  output  2  drives mux select `S`.
- data  output  4  scan result; data[i] = f_in sampled while sel==i.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when data is updated.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; there is no asynchronous reset path.
- Reset values: sel=0, data=0, busy=0, done=0, internal shadow=0, wait counter=0, state=IDLE.
- States: IDLE, SETTLE, SAMPLE. busy = (state != IDLE), decoded combinationally from the state register.
- IDLE:
  - sel held at 0.
  - start=1 at an edge → SETTLE, wait counter loaded with SETTLE-1.
  - start=0 → remain in IDLE.
- SETTLE:
  - sel is stable.
  - wcnt==0 → SAMPLE; otherwise wcnt decrements.
- SAMPLE (exactly one cycle):
  - shadow[sel] <= f_in.
  - If sel != 3: sel <= sel+1, wcnt reloaded with SETTLE-1, → SETTLE.
  - If sel == 3: data <= {f_in, shadow[2:0]}, done <= 1, sel <= 0, → IDLE.
- Latency: done is high in the cycle following edge 4*(SETTLE+1), counted from the edge that accepted start. With SETTLE=1, done rises 8 edges after acceptance.
- data changes only on the done edge and holds its value between scans.
- done is registered and self-clears on the next edge.
- sel changes only on SAMPLE→SETTLE edges or on scan completion, so it is glitch-free for the mux.
- start while busy: ignored, no queuing.
- start high in the same cycle done is high: accepted, because the state is already IDLE. The new scan begins with 1 idle cycle between scans.
- Reset mid-scan: all outputs return to reset values on that edge, the partial shadow is discarded, and no done is issued.
- f_in is treated as synchronous to clk; the block has no synchroniser.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined: on the final SAMPLE, if start==1, the block goes directly to SETTLE with sel=0 instead of IDLE. busy stays high with no idle gap, and done still pulses per scan. Back-to-back scans take 4*(SETTLE+1) cycles each.
- Undefined: always returns to IDLE after a scan, so back-to-back scans take 4*(SETTLE+1)+1 cycles.

Decomposition:
- Shared package/include mux_scan_pkg:
  - state encoding localparams: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2.
  - SEL_W=2, NCH=4, WCNT_W=4.
- One natural sub-module: settle_timer.
  - Load/decrement counter.
  - Inputs: load, load value.
  - Output: zero flag.
- The FSM, sel counter and shadow/data registers stay in mux_scan_ctrl.

Test Plan:
- Bench instantiates mux_scan_ctrl with mux4to1 in the loop (w3..w0 = stimulus, S=sel, f→f_in).
- Reset then idle: rst=1 for 2 cycles → sel=0, data=0, busy=0, done=0; they stay so with start=0 for 10 cycles.
- Basic scan, SETTLE=1, w3..w0=4'b1010, start pulsed one cycle:
  - busy=1 for 8 cycles.
  - sel sequence 0,0,1,1,2,2,3,3.
  - done pulse 1 cycle, data=4'b1010.
- SETTLE=3, w=4'b0111 → done after 16 edges, data=4'b0111. Changing w after done leaves data unchanged.
- Scan w=4'b0001, pulse start again mid-scan (cycle 3) → no restart; a single done with data=4'b0001.
- rst asserted at cycle 5 of a scan with w=4'b1111:
  - next edge: all outputs 0 and no done.
  - new scan → data=4'b1111.
- start held high with w=4'b0110:
  - without MUX_SCAN_CONT_EN: done pulses every 9 cycles.
  - with MUX_SCAN_CONT_EN (SETTLE=1): done pulses every 8 cycles, busy stays 1, data=4'b0110 each time.
